serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial subtractor: computes Diff = A - B, LSB first, one bit per clock.
//  Uses a single full-subtractor cell and a borrow flip-flop, the inverse of the adder datapath.
//  Loads A and B on a start pulse and shifts out the result over WIDTH cycles.
//  Pulses done when the result is ready.
//  Sits beside the adder blocks as the area-cheap subtraction path for multi-cycle ALU ops.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      load A,B and begin; sampled only in IDLE or DONE
//  A      in   WIDTH  minuend, captured on accepted start
//  B      in   WIDTH  subtrahend, captured on accepted start
//  busy   out  1      high while in SHIFT
//  done   out  1      one-cycle pulse: Diff/Bout valid
//  Diff   out  WIDTH  A - B modulo 2^WIDTH; held until next accepted start
//  Bout   out  1      final borrow (1 when A < B unsigned); held with Diff
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; busy=0, done=0, Diff=0, Bout=0.
//   Also clears the shift registers, borrow FF and bit counter.
//  FSM states:
//   IDLE -> SHIFT on start.
//   SHIFT -> DONE when bit counter reaches WIDTH-1.
//   DONE -> SHIFT if start, else IDLE.
//  Accepted start edge:
//   areg<=A, breg<=B, br<=0, cnt<=0, busy<=1.
//   Diff is cleared to 0 on load.
//  SHIFT, each cycle, with a0=areg[0], b0=breg[0]:
//   d = a0^b0^br
//   br_next = (~a0&b0) | (~(a0^b0)&br)
//   Diff <= {d, Diff[WIDTH-1:1]}; areg/breg shift right by 1; cnt++.
//  On last SHIFT cycle (cnt==WIDTH-1): Bout<=br_next; next state DONE.
//  DONE state: done=1, busy=0 for exactly one cycle.
//  Latency: start sampled at edge N -> done high in the cycle after edge N+WIDTH.
//   Back-to-back: start sampled during DONE restarts with no idle gap.
//  start while busy=1: ignored; operands and result are unaffected.
//  A/B changing after load: no effect until next accepted start.
//  rst asserted mid-SHIFT: immediate return to reset values; partial result is discarded.
//  Result arithmetic: unsigned modulo-2^WIDTH; also correct as two's-complement difference.
//   Bout is the unsigned borrow, not a signed overflow flag.
// TESTING (WIDTH=8)
//  T1 A=5, B=3, start -> after 8 shift cycles done=1, Diff=0x02, Bout=0.
//  T2 A=3, B=5 -> Diff=0xFE, Bout=1.
//     Also A=0x00, B=0xFF -> Diff=0x01, Bout=1.
//     Also A=0xFF, B=0xFF -> Diff=0x00, Bout=0.
//  T3 start pulsed again 3 cycles into a run with A=0x10, B=0x01 ->
//     ignored; original A=0x80, B=0x01 yields Diff=0x7F, Bout=0 at the original done time.
//  T4 rst raised mid-SHIFT (cycle 4) -> same cycle busy=0, done=0, Diff=0, Bout=0;
//     a new start after release gives the correct result.
//  T5 start held high through DONE -> second operation begins next cycle.
//     done pulses every 9 cycles; each Diff matches the reference model.
//  T6 random 1000 operand pairs vs. golden (A-B)&0xFF and (A<B) -> zero mismatches;
//     busy/done never high simultaneously.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master: issues start with operands A/B and observes busy/done/Diff/Bout.
// slave : the subtractor itself; consumes start/A/B and drives the status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;

    modport master (
        output start, A, B,
        input  busy, done, Diff, Bout
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B, LSB first, one full-subtractor cell plus a borrow flop.
// Latency: start sampled at edge N -> done pulses in the cycle after edge N+WIDTH.
// No backpressure: start is accepted only in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus.start  load A/B and begin (accepted in IDLE or DONE only)
//   bus.A/B    minuend / subtrahend, captured on an accepted start
//   bus.busy   high while bits are being shifted
//   bus.done   one-cycle pulse, Diff/Bout valid
//   bus.Diff   A - B modulo 2^WIDTH, held until the next accepted start
//   bus.Bout   final unsigned borrow (A < B), held with Diff
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             busy_q;
    logic             done_q;
    logic             bout_q;

    // Full-subtractor cell operating on the current LSBs.
    logic a0;
    logic b0;
    logic d;
    logic br_next;

    always_comb begin
        a0      = areg[0];
        b0      = breg[0];
        d       = a0 ^ b0 ^ br;
        // Borrow out when a0 < b0, or when the bits are equal and a borrow came in.
        br_next = (~a0 & b0) | (~(a0 ^ b0) & br);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            areg   <= '0;
            breg   <= '0;
            diff_q <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bout_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // done is a single-cycle pulse; leaving DONE always drops it.
                    done_q <= 1'b0;
                    if (bus.start) begin
                        areg   <= bus.A;
                        breg   <= bus.B;
                        br     <= 1'b0;
                        cnt    <= '0;
                        diff_q <= '0;
                        bout_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end

                SHIFT: begin
                    // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                    diff_q <= {d, diff_q[WIDTH-1:1]};
                    areg   <= {1'b0, areg[WIDTH-1:1]};
                    breg   <= {1'b0, breg[WIDTH-1:1]};
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bout_q <= br_next;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end

                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed table, multi-cycle
// corner sequences and randomized operands against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W       = 8;
    localparam int LAT     = W + 1;   // negedges from start drive to done visible
    localparam int MAXWAIT = 30;

    logic clk;
    logic rst;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bout;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain modular arithmetic and unsigned compare.
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned r;
        r = (int'(a) - int'(b) + 256) % 256;
        return W'(r);
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] a, input logic [W-1:0] b);
        return (int'(a) < int'(b));
    endfunction

    // Called at a negedge. Drives start with operands, then scrambles A/B after the
    // load edge; returns the result and the number of negedges until done was seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] diff, output logic bout, output int lat);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        lat       = -1;
        for (int i = 1; i <= MAXWAIT; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.start = 1'b0;
                bus.A     = W'($urandom);
                bus.B     = W'($urandom);
            end
            chk("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        diff = bus.Diff;
        bout = bus.Bout;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [W-1:0] d;
        logic         bo;
        int           lat;

        n_vec = 0;
        n_err = 0;

        tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        tbl[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        tbl[5] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        tbl[6] = '{8'hAA, 8'h55, 8'h55, 1'b0};
        tbl[7] = '{8'h01, 8'h00, 8'h01, 1'b0};

        // Reset state
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_diff", {24'd0, bus.Diff}, 32'd0);
        chk("rst_bout", {31'd0, bus.Bout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table, each op followed by an idle cycle to check result hold
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, d, bo, lat);
            chk("tbl_latency", 32'(lat), 32'(LAT));
            chk("tbl_diff", {24'd0, d}, {24'd0, tbl[i].diff});
            chk("tbl_bout", {31'd0, bo}, {31'd0, tbl[i].bout});
            @(negedge clk);
            chk("tbl_done_pulse", {31'd0, bus.done}, 32'd0);
            chk("tbl_diff_hold", {24'd0, bus.Diff}, {24'd0, tbl[i].diff});
        end

        // Start pulsed 3 cycles into a run must be ignored
        begin
            int seen;
            seen      = -1;
            bus.start = 1'b1;
            bus.A     = 8'h80;
            bus.B     = 8'h01;
            for (int i = 1; i <= MAXWAIT; i++) begin
                @(negedge clk);
                if (i == 1) bus.start = 1'b0;
                if (i == 3) begin
                    bus.start = 1'b1;
                    bus.A     = 8'h10;
                    bus.B     = 8'h01;
                end
                if (i == 4) begin
                    bus.start = 1'b0;
                    chk("ign_busy", {31'd0, bus.busy}, 32'd1);
                end
                if (bus.done) begin
                    seen = i;
                    break;
                end
            end
            chk("ign_latency", 32'(seen), 32'(LAT));
            chk("ign_diff", {24'd0, bus.Diff}, 32'h7F);
            chk("ign_bout", {31'd0, bus.Bout}, 32'd0);
            @(negedge clk);
        end

        // Reset mid-shift discards partial result
        bus.start = 1'b1;
        bus.A     = 8'hFF;
        bus.B     = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
        chk("mid_rst_diff", {24'd0, bus.Diff}, 32'd0);
        chk("mid_rst_bout", {31'd0, bus.Bout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {31'd0, bus.busy}, 32'd0);
        run_op(8'h37, 8'h12, d, bo, lat);
        chk("post_rst_latency", 32'(lat), 32'(LAT));
        chk("post_rst_diff", {24'd0, d}, 32'h25);
        chk("post_rst_bout", {31'd0, bo}, 32'd0);
        @(negedge clk);

        // start held high: back-to-back ops, done every W+1 cycles
        begin
            logic [W-1:0] oa [4];
            logic [W-1:0] ob [4];
            int k;
            int last_t;
            for (int i = 0; i < 4; i++) begin
                oa[i] = W'($urandom);
                ob[i] = W'($urandom);
            end
            k         = 0;
            last_t    = 0;
            bus.start = 1'b1;
            bus.A     = oa[0];
            bus.B     = ob[0];
            for (int t = 1; t <= 60 && k < 4; t++) begin
                @(negedge clk);
                chk("b2b_excl", {31'd0, bus.busy & bus.done}, 32'd0);
                if (bus.done) begin
                    chk("b2b_interval", 32'(t - last_t), 32'(LAT));
                    chk("b2b_diff", {24'd0, bus.Diff}, {24'd0, ref_diff(oa[k], ob[k])});
                    chk("b2b_bout", {31'd0, bus.Bout}, {31'd0, ref_bout(oa[k], ob[k])});
                    last_t = t;
                    k++;
                    if (k < 4) begin
                        bus.A = oa[k];
                        bus.B = ob[k];
                    end else begin
                        bus.start = 1'b0;
                    end
                end
            end
            bus.start = 1'b0;
            chk("b2b_count", 32'(k), 32'd4);
            @(negedge clk);
        end

        // Randomized operands, mostly back-to-back restarts from DONE
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ra = rb;
            end
            run_op(ra, rb, d, bo, lat);
            chk("rnd_latency", 32'(lat), 32'(LAT));
            chk("rnd_diff", {24'd0, d}, {24'd0, ref_diff(ra, rb)});
            chk("rnd_bout", {31'd0, bo}, {31'd0, ref_bout(ra, rb)});
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
